// File: rtl/mem_arbiter_pkg.sv
// Shared memory geometry and request record for the single-port memory arbiter.
// Geometry matches the 256x64 synchronous memory behind the arbiter.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 64;
   localparam int MEM_DEPTH  = 256;

   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
   typedef logic [MEM_DATA_W-1:0] mem_data_t;

   typedef struct packed {
      logic      write;
      mem_addr_t addr;
      mem_data_t wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping.
// Zero latency; gnt is all-zero when no request is asserted.
module rr_arbiter #(
   parameter int N    = 2,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = ID_W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256x64 synchronous memory between NUM_REQ requesters.
// One acceptance per cycle, read data returned one cycle later with no backpressure.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_W-1:0]               rsp_data,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_write_data,
   output logic                            mem_write_enable,
   input  logic [DATA_W-1:0]               mem_read_data
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    gnt_id;
   logic [NUM_REQ-1:0] gnt;
   logic               accept;
   mem_req_t           sel;
   logic               pend_valid;
   logic [ID_W-1:0]    pend_id;
   mem_addr_t          last_addr;

   rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // No grant is offered while reset is held.
   assign accept    = rst && (|gnt);
   assign req_ready = accept ? gnt : '0;

   always_comb begin
      sel.write = req_write[gnt_id];
      sel.addr  = req_addr[gnt_id];
      sel.wdata = req_wdata[gnt_id];
   end

   assign mem_addr         = accept ? sel.addr  : last_addr;
   assign mem_write_data   = accept ? sel.wdata : '0;
   assign mem_write_enable = accept && sel.write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= '0;
         pend_valid <= 1'b0;
         pend_id    <= '0;
         last_addr  <= '0;
      end else begin
         pend_valid <= accept && !sel.write;
         if (accept) begin
            rr_ptr    <= gnt_id;
            last_addr <= sel.addr;
            if (!sel.write) pend_id <= gnt_id;
         end
      end
   end

   // The memory registers its read data, so it lines up with pend_* in the following cycle.
   always_comb begin
      rsp_valid = '0;
      if (pend_valid) rsp_valid[pend_id] = 1'b1;
   end

   assign rsp_data = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences and
// randomized traffic checked against a transaction-level model with its own memory image.
module tb_mem_arbiter;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_write = '0;
   logic [1:0][7:0]  req_addr  = '0;
   logic [1:0][63:0] req_wdata = '0;
   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;
   logic [63:0]      rsp_data;
   logic [7:0]       mem_addr;
   logic [63:0]      mem_write_data;
   logic             mem_write_enable;
   logic [63:0]      mem_read_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_ready        (req_ready),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
   );

   // Environment memory: synchronous, registered read, read-before-write on a shared address.
   logic        init_done = 1'b0;
   logic [63:0] tb_mem [256];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
         mem_read_data <= '0;
      end else begin
         if (mem_write_enable) tb_mem[mem_addr] <= mem_write_data;
         mem_read_data <= tb_mem[mem_addr];
      end
   end

   // Transaction-level reference state.
   int          m_ptr;
   bit          m_pend_v;
   int          m_pend_id;
   logic [63:0] m_pend_data;
   logic [7:0]  m_last_addr;
   logic [63:0] ref_mem [256];

   task automatic model_reset();
      m_ptr       = 0;
      m_pend_v    = 0;
      m_pend_id   = 0;
      m_pend_data = '0;
      m_last_addr = '0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1,
                       output logic [1:0] o_rdy, output logic [1:0] o_rv,
                       output logic [63:0] o_rd);
      logic [7:0]  a [2];
      logic [63:0] d [2];
      logic [1:0]  exp_rv;
      int          g;
      a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      @(negedge clk);
      req_valid    = v;
      req_write    = w;
      req_addr[0]  = a0;
      req_addr[1]  = a1;
      req_wdata[0] = d0;
      req_wdata[1] = d1;
      #1;
      o_rdy = req_ready;
      o_rv  = rsp_valid;
      o_rd  = rsp_data;
      exp_rv = m_pend_v ? (2'b01 << m_pend_id) : 2'b00;
      chk("model_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (m_pend_v) chk("model_rsp_data", rsp_data, m_pend_data);
      g = -1;
      for (int k = 1; k <= 2; k++) begin
         int idx;
         idx = (m_ptr + k) % 2;
         if (g < 0 && v[idx]) g = idx;
      end
      chk("model_req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      chk("model_mem_we", 64'(mem_write_enable), (g >= 0) ? 64'(w[g]) : 64'd0);
      chk("model_mem_addr", 64'(mem_addr), (g >= 0) ? 64'(a[g]) : 64'(m_last_addr));
      if (g >= 0 && w[g]) chk("model_mem_wdata", mem_write_data, d[g]);
      m_pend_v = 0;
      if (g >= 0) begin
         m_ptr       = g;
         m_last_addr = a[g];
         if (w[g]) begin
            ref_mem[a[g]] = d[g];
         end else begin
            m_pend_v    = 1;
            m_pend_id   = g;
            m_pend_data = ref_mem[a[g]];
         end
      end
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  w;
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  e_rdy;
      logic [1:0]  e_rv;
      logic [63:0] e_rd;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [1:0]  o_rdy, o_rv;
      logic [63:0] o_rd;

      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      model_reset();

      // Write/read, contention from ptr=0, then same-cycle write vs read of one address.
      tbl.push_back('{2'b01, 2'b01, 8'h10, 8'h00, 64'hDEADBEEF_00000001, 64'h0, 2'b01, 2'b00, 64'h0});
      tbl.push_back('{2'b01, 2'b00, 8'h10, 8'h00, 64'h0, 64'h0, 2'b01, 2'b00, 64'h0});
      tbl.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b01, 64'hDEADBEEF_00000001});
      tbl.push_back('{2'b10, 2'b10, 8'h00, 8'h01, 64'h0, 64'hA1, 2'b10, 2'b00, 64'h0});
      tbl.push_back('{2'b10, 2'b10, 8'h00, 8'h02, 64'h0, 64'hB2, 2'b10, 2'b00, 64'h0});
      tbl.push_back('{2'b01, 2'b00, 8'h10, 8'h00, 64'h0, 64'h0, 2'b01, 2'b00, 64'h0});
      tbl.push_back('{2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, 2'b10, 2'b01, 64'hDEADBEEF_00000001});
      tbl.push_back('{2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, 2'b01, 2'b10, 64'hB2});
      tbl.push_back('{2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, 2'b10, 2'b01, 64'hA1});
      tbl.push_back('{2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, 2'b01, 2'b10, 64'hB2});
      tbl.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b01, 64'hA1});
      tbl.push_back('{2'b11, 2'b01, 8'h20, 8'h20, 64'h5, 64'h0, 2'b10, 2'b00, 64'h0});
      tbl.push_back('{2'b11, 2'b01, 8'h20, 8'h20, 64'h5, 64'h0, 2'b01, 2'b10, 64'h0});
      tbl.push_back('{2'b10, 2'b00, 8'h00, 8'h20, 64'h0, 64'h0, 2'b10, 2'b00, 64'h0});
      tbl.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b10, 64'h5});

      // Reset state with no requests.
      @(posedge clk);
      init_done = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_mem_we", 64'(mem_write_enable), 64'd0);
      chk("reset_mem_addr", 64'(mem_addr), 64'd0);
      rst = 1'b1;
      step(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, o_rdy, o_rv, o_rd);
      chk("idle_mem_we", 64'(mem_write_enable), 64'd0);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, o_rdy, o_rv, o_rd);
         chk($sformatf("vec%0d_ready", i), 64'(o_rdy), 64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_rsp_valid", i), 64'(o_rv), 64'(tbl[i].e_rv));
         if (tbl[i].e_rv != 2'b00) chk($sformatf("vec%0d_rsp_data", i), o_rd, tbl[i].e_rd);
      end

      // Reset asserted right after a read is accepted: the response must not appear.
      @(negedge clk);
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 8'h10;
      @(posedge clk);
      #1 rst = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      chk("midrst_mem_we", 64'(mem_write_enable), 64'd0);
      chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      chk("midrst_rsp_valid2", 64'(rsp_valid), 64'd0);
      model_reset();
      req_valid = 2'b00;
      rst = 1'b1;
      step(2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, o_rdy, o_rv, o_rd);
      chk("postrst_grant", 64'(o_rdy), 64'b10);
      chk("postrst_no_rsp", 64'(o_rv), 64'd0);

      // Pipelined stream: preload addr*3 then read 0..7 back-to-back.
      for (int i = 0; i < 8; i++)
         step(2'b01, 2'b01, 8'(i), 8'h00, 64'(i * 3), 64'h0, o_rdy, o_rv, o_rd);
      for (int k = 0; k <= 8; k++) begin
         step((k < 8) ? 2'b01 : 2'b00, 2'b00, 8'(k), 8'h00, 64'h0, 64'h0, o_rdy, o_rv, o_rd);
         if (k >= 1) begin
            chk($sformatf("stream%0d_rsp_valid", k - 1), 64'(o_rv), 64'b01);
            chk($sformatf("stream%0d_rsp_data", k - 1), o_rd, 64'((k - 1) * 3));
         end
      end

      // Randomized traffic against the model; small address range forces collisions.
      for (int n = 0; n < 600; n++) begin
         logic [1:0] rv;
         rv = (n % 5 == 0) ? 2'b11 : 2'($urandom_range(0, 3));
         step(rv, 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom}, o_rdy, o_rv, o_rd);
      end
      step(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, o_rdy, o_rv, o_rd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
